udt_config_selftest: RTL and testbench
======================================

Name: udt_config_selftest

Overview:
- Self-checking UDT configuration block: an 8-entry socket-option register bank plus a built-in sequencer.
- After reset the sequencer checks reset values, runs TEST_NUM write/read-back passes, then raises finish; any mismatch raises err.
- Sits beside the UDT datapath in the simulation top. The top stops when all finish bits are 1 or any err bit is 1.

Parameters:
- TEST_NUM, 2, number of write/read-back passes (1..255).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- inject_err  input  1  when 1, bit 0 of every sequencer write is inverted before it reaches the bank; tie 0 in normal use.
- finish  output  1  sticky; 1 when the sequence has ended (pass or fail).
- err  output  1  sticky; 1 when any compare failed.
- fail_addr  output  3  address of the first failing register; 0 if none.

Behaviour:
- Register bank (index: name, writable mask, reset value):
  - 0: MSS, mask 0x0000FFFF, reset 0x000005DC.
  - 1: FLIGHT_FLAG_SIZE, mask 0xFFFFFFFF, reset 0x00006400.
  - 2: SND_BUF, mask 0xFFFFFFFF, reset 0x00002000.
  - 3: RCV_BUF, mask 0xFFFFFFFF, reset 0x00002000.
  - 4: LINGER, mask 0x0000FFFF, reset 0x000000B4.
  - 5: RENDEZVOUS, mask 0x00000001, reset 0.
  - 6: MAX_BW, mask 0xFFFFFFFF, reset 0xFFFFFFFF.
  - 7: VERSION, read-only constant 0x00000004; writes are ignored.
- Bank access rules:
  - Write: stored = wdata & mask, committed on the write cycle edge.
  - Read: registered, 1-cycle latency; returns stored value with unmasked bits reading 0.
- Sequencer FSM states: IDLE, CHK_RD, CHK_CMP, WR, RD, CMP, DONE.
  - IDLE: entered on reset; moves to CHK_RD on the first clk edge after rst_n=1.
  - CHK_RD/CHK_CMP: for addr 0..7, issue a read, then compare against the reset value. 2 cycles per address, 16 total.
  - WR/RD/CMP: for pass p = 0..TEST_NUM-1 and addr 0..7: write pattern, issue read, compare against expected. 3 cycles per address.
  - Pattern: P = 32'hA5C30000 | (p << 8) | addr; invert all bits when p is odd.
  - Expected value: P & mask[addr]; for addr 7, always 0x00000004.
  - DONE: terminal state until reset.
- Compare failure:
  - Sets err=1 and fail_addr=addr, both in the cycle after the CMP/CHK_CMP edge.
  - The FSM jumps directly to DONE.
- finish:
  - Set when DONE is entered.
  - With no errors, finish rises at edge 2 + 16 + 24*TEST_NUM after reset release; for TEST_NUM=2 that is edge 66.
- Reset values: finish=0, err=0, fail_addr=0, bank at reset values, pass/addr counters 0, FSM in IDLE.
- Reset asserted mid-sequence: all state clears immediately (asynchronous); the sequence restarts from IDLE on release.
- Only the sequencer writes the bank; there is no external bus.
- Pass and address counters wrap only at their terminal counts: addr 7→0 advances the pass; the last pass goes to DONE.
- err and finish never deassert except on reset. err=1 always implies finish=1.
- Outputs are registered and glitch-free.

Test Plan:
- Normal run, TEST_NUM=2, inject_err=0, release rst_n at cycle 5:
  - finish rises exactly 66 edges after release; err=0, fail_addr=0.
  - Both stay stable for the next 1000 cycles.
- inject_err=1 from reset:
  - Reset checks pass; the first write (addr 0, pattern 0xA5C30000) stores 0x00000001 & mask and mismatches.
  - err=1, finish=1, fail_addr=0 at edge 2+16+3.
- Reset pulse (rst_n=0 for 2 cycles) at cycle 30 of a normal run:
  - finish, err and fail_addr drop to 0 immediately.
  - A full sequence reruns, and finish rises 66 edges after the second release.
- TEST_NUM=1: finish at edge 42, err=0.
- Hierarchical peeks during pass 1 (odd, inverted pattern):
  - MSS reads 0x0000FEFF.
  - RENDEZVOUS reads 0x00000000.
  - VERSION reads 0x00000004.
  - MAX_BW reads 0x5A3CFEF9.
- inject_err toggled to 1 only after DONE: no change to err or finish.

Source files
------------

// File: rtl/udt_config_selftest_if.sv
// Status/control bundle of the UDT configuration self-test block.
// The block drives the sticky result flags; the surrounding top drives the
// error-injection control.
interface udt_config_selftest_if;
    logic       inject_err;
    logic       finish;
    logic       err;
    logic [2:0] fail_addr;

    // Simulation top / bench side
    modport master (
        output inject_err,
        input  finish,
        input  err,
        input  fail_addr
    );

    // Self-test block side
    modport slave (
        input  inject_err,
        output finish,
        output err,
        output fail_addr
    );
endinterface

// File: rtl/udt_config_selftest.sv
// UDT socket-option register bank with a built-in self-test sequencer.
// After reset the sequencer reads every register and compares it with its
// reset value. It then runs TEST_NUM write/read-back passes and finally
// raises a sticky finish flag. A miscompare stops the sequence, latches
// the failing address and raises a sticky err flag.
module udt_config_selftest #(
    parameter int TEST_NUM = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udt_config_selftest_if.slave cfg
);

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] VERSION_VAL = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE,
        CHK_RD,
        CHK_CMP,
        WR,
        RD,
        CMP,
        DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          addr_q;
    logic [7:0]          pass_q;
    logic [DATA_W-1:0]   bank_q [0:7];
    logic [DATA_W-1:0]   rdata_q;
    logic                mism_q;
    logic [2:0]          mism_addr_q;
    logic                finish_q;
    logic                err_q;
    logic [2:0]          fail_addr_q;

    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   expect_d;
    logic                mismatch_d;

    // Writable-bit mask for each option register; VERSION has none.
    function automatic logic [DATA_W-1:0] mask_of(input logic [2:0] a);
        case (a)
            3'd0:    mask_of = 32'h0000_FFFF;
            3'd1:    mask_of = 32'hFFFF_FFFF;
            3'd2:    mask_of = 32'hFFFF_FFFF;
            3'd3:    mask_of = 32'hFFFF_FFFF;
            3'd4:    mask_of = 32'h0000_FFFF;
            3'd5:    mask_of = 32'h0000_0001;
            3'd6:    mask_of = 32'hFFFF_FFFF;
            default: mask_of = 32'h0000_0000;
        endcase
    endfunction

    // Power-on value of each option register.
    function automatic logic [DATA_W-1:0] reset_of(input logic [2:0] a);
        case (a)
            3'd0:    reset_of = 32'h0000_05DC;
            3'd1:    reset_of = 32'h0000_6400;
            3'd2:    reset_of = 32'h0000_2000;
            3'd3:    reset_of = 32'h0000_2000;
            3'd4:    reset_of = 32'h0000_00B4;
            3'd5:    reset_of = 32'h0000_0000;
            3'd6:    reset_of = 32'hFFFF_FFFF;
            default: reset_of = VERSION_VAL;
        endcase
    endfunction

    // Test pattern: pass number in bits 15:8, address in the low bits,
    // fully inverted on odd passes so every bit is exercised both ways.
    function automatic logic [DATA_W-1:0] pattern_of(input logic [7:0] p,
                                                     input logic [2:0] a);
        logic [DATA_W-1:0] v;
        v = 32'hA5C3_0000 | {16'h0000, p, 8'h00} | {29'd0, a};
        pattern_of = p[0] ? ~v : v;
    endfunction

    // Write data, expected read-back value and compare result.
    always_comb begin
        wdata_d  = pattern_of(pass_q, addr_q) ^ {{(DATA_W-1){1'b0}}, cfg.inject_err};
        expect_d = reset_of(addr_q);
        if (state_q == CMP) begin
            expect_d = (addr_q == 3'd7) ? VERSION_VAL
                                        : (pattern_of(pass_q, addr_q) & mask_of(addr_q));
        end
        mismatch_d = (rdata_q != expect_d);
    end

    // Option register bank: masked writes from the sequencer, VERSION fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                bank_q[i] <= reset_of(3'(i));
            end
        end else if (state_q == WR && addr_q != 3'd7) begin
            bank_q[addr_q] <= wdata_d & mask_of(addr_q);
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state_q == CHK_RD || state_q == RD) begin
            rdata_q <= bank_q[addr_q] & ((addr_q == 3'd7) ? 32'hFFFF_FFFF : mask_of(addr_q));
        end
    end

    // Sequencer with registered sticky result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pass_q      <= '0;
            mism_q      <= 1'b0;
            mism_addr_q <= '0;
            finish_q    <= 1'b0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            // Flags follow the sequencer state one cycle later; DONE is
            // terminal, so a recorded miscompare is only ever latched once.
            finish_q <= finish_q | (state_q == DONE);
            err_q    <= err_q | mism_q;
            if (mism_q && !err_q) begin
                fail_addr_q <= mism_addr_q;
            end

            case (state_q)
                IDLE: begin
                    addr_q  <= '0;
                    pass_q  <= '0;
                    state_q <= CHK_RD;
                end
                CHK_RD: begin
                    state_q <= CHK_CMP;
                end
                CHK_CMP: begin
                    if (mismatch_d) begin
                        mism_q      <= 1'b1;
                        mism_addr_q <= addr_q;
                        state_q     <= DONE;
                    end else if (addr_q == 3'd7) begin
                        addr_q  <= '0;
                        pass_q  <= '0;
                        state_q <= WR;
                    end else begin
                        addr_q  <= addr_q + 3'd1;
                        state_q <= CHK_RD;
                    end
                end
                WR: begin
                    state_q <= RD;
                end
                RD: begin
                    state_q <= CMP;
                end
                CMP: begin
                    if (mismatch_d) begin
                        mism_q      <= 1'b1;
                        mism_addr_q <= addr_q;
                        state_q     <= DONE;
                    end else if (addr_q == 3'd7) begin
                        addr_q <= '0;
                        if (pass_q == 8'(TEST_NUM - 1)) begin
                            state_q <= DONE;
                        end else begin
                            pass_q  <= pass_q + 8'd1;
                            state_q <= WR;
                        end
                    end else begin
                        addr_q  <= addr_q + 3'd1;
                        state_q <= WR;
                    end
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    assign cfg.finish    = finish_q;
    assign cfg.err       = err_q;
    assign cfg.fail_addr = fail_addr_q;

endmodule

// File: tb/tb_udt_config_selftest.sv
// Bench for udt_config_selftest: two instances (TEST_NUM=2 and TEST_NUM=1),
// a scoreboard of expected finish events per instance and direct checks of
// reset behaviour and bank contents.
module tb_udt_config_selftest;

    typedef struct {
        int         edge_n;
        logic       err;
        logic [2:0] fail_addr;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rst2_n;

    int n_chk;
    int n_fail;

    exp_t q1[$];
    exp_t q2[$];

    int   cnt1;
    int   cnt2;
    logic fin_prev1;
    logic fin_prev2;

    udt_config_selftest_if bus1 ();
    udt_config_selftest_if bus2 ();

    udt_config_selftest #(.TEST_NUM(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .cfg   (bus1.slave)
    );

    udt_config_selftest #(.TEST_NUM(1)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .cfg   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endfunction

    // Edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt1 <= 0;
        else        cnt1 <= cnt1 + 1;
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) cnt2 <= 0;
        else         cnt2 <= cnt2 + 1;
    end

    // Monitor for instance 1: compare each finish rising edge with the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fin_prev1 = 1'b0;
        end else begin
            if (bus1.finish === 1'b1 && !fin_prev1) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut1_unexpected_finish: got finish at edge %0d, expected none", cnt1);
                end else begin
                    e = q1.pop_front();
                    check("dut1_finish_edge", 32'(cnt1), 32'(e.edge_n));
                    check("dut1_err", {31'd0, bus1.err}, {31'd0, e.err});
                    check("dut1_fail_addr", {29'd0, bus1.fail_addr}, {29'd0, e.fail_addr});
                end
            end
            fin_prev1 = bus1.finish;
        end
    end

    // Monitor for instance 2.
    always @(negedge clk) begin
        exp_t e;
        if (!rst2_n) begin
            fin_prev2 = 1'b0;
        end else begin
            if (bus2.finish === 1'b1 && !fin_prev2) begin
                if (q2.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut2_unexpected_finish: got finish at edge %0d, expected none", cnt2);
                end else begin
                    e = q2.pop_front();
                    check("dut2_finish_edge", 32'(cnt2), 32'(e.edge_n));
                    check("dut2_err", {31'd0, bus2.err}, {31'd0, e.err});
                    check("dut2_fail_addr", {29'd0, bus2.fail_addr}, {29'd0, e.fail_addr});
                end
            end
            fin_prev2 = bus2.finish;
        end
    end

    task automatic wait_finish(input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 1 && bus1.finish === 1'b1) || (sel == 2 && bus2.finish === 1'b1)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d_finish_timeout: got no finish within %0d cycles, expected finish", sel, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bit   unstable;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        bus1.inject_err = 1'b0;
        bus2.inject_err = 1'b0;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_finish", {31'd0, bus1.finish}, 32'd0);
        check("rst_err", {31'd0, bus1.err}, 32'd0);
        check("rst_fail_addr", {29'd0, bus1.fail_addr}, 32'd0);
        check("rst_bank_mss", dut1.bank_q[0], 32'h0000_05DC);
        check("rst_bank_maxbw", dut1.bank_q[6], 32'hFFFF_FFFF);

        // Normal run, TEST_NUM=2.
        e = '{edge_n: 66, err: 1'b0, fail_addr: 3'd0};
        q1.push_back(e);
        rst_n = 1'b1;
        wait_finish(1, 200);

        // Bank holds the odd (inverted) pass patterns.
        check("peek_mss", dut1.bank_q[0], 32'h0000_FEFF);
        check("peek_flight", dut1.bank_q[1], 32'h5A3C_FEFE);
        check("peek_rendezvous", dut1.bank_q[5], 32'h0000_0000);
        check("peek_maxbw", dut1.bank_q[6], 32'h5A3C_FEF9);
        check("peek_version_read", dut1.rdata_q, 32'h0000_0004);

        // Outputs stay put for 1000 cycles.
        unstable = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (bus1.finish !== 1'b1 || bus1.err !== 1'b0 || bus1.fail_addr !== 3'd0)
                unstable = 1'b1;
        end
        check("stable_1000", {31'd0, unstable}, 32'd0);

        // inject_err after DONE has no effect.
        bus1.inject_err = 1'b1;
        repeat (20) @(negedge clk);
        check("late_inject_err", {31'd0, bus1.err}, 32'd0);
        check("late_inject_finish", {31'd0, bus1.finish}, 32'd1);
        bus1.inject_err = 1'b0;

        // Asynchronous clear of finish, mid-cycle.
        #2 rst_n = 1'b0;
        #1 check("async_clear_finish", {31'd0, bus1.finish}, 32'd0);
        repeat (2) @(negedge clk);

        // Reset pulse at cycle 30 of a normal run.
        e = '{edge_n: 66, err: 1'b0, fail_addr: 3'd0};
        q1.push_back(e);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("pulse_finish", {31'd0, bus1.finish}, 32'd0);
        check("pulse_err", {31'd0, bus1.err}, 32'd0);
        check("pulse_addr_cnt", {29'd0, dut1.addr_q}, 32'd0);
        check("pulse_bank_mss", dut1.bank_q[0], 32'h0000_05DC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_finish(1, 200);

        // Error injection from reset: first write miscompares at addr 0.
        rst_n = 1'b0;
        bus1.inject_err = 1'b1;
        repeat (2) @(negedge clk);
        e = '{edge_n: 21, err: 1'b1, fail_addr: 3'd0};
        q1.push_back(e);
        rst_n = 1'b1;
        wait_finish(1, 100);
        check("inject_bank_mss", dut1.bank_q[0], 32'h0000_0001);
        check("inject_err_sticky", {31'd0, bus1.err}, 32'd1);

        // Asynchronous clear of err, mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check("async_clear_err", {31'd0, bus1.err}, 32'd0);
        check("async_clear_fin2", {31'd0, bus1.finish}, 32'd0);
        bus1.inject_err = 1'b0;

        // TEST_NUM=1 instance.
        e = '{edge_n: 42, err: 1'b0, fail_addr: 3'd0};
        q2.push_back(e);
        @(negedge clk);
        rst2_n = 1'b1;
        wait_finish(2, 100);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
